// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage: DEPTH register slices in series with valid/ready
// handshaking, bubble collapsing, flush and an occupancy counter.
// Optional feature: define PIPE_STAGE_REG_SKID_EN to insert a one-entry skid
// register ahead of slice 1, which registers in_ready (no combinational path
// from out_ready) and raises capacity to DEPTH+1.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [2:0]        occupancy
);

  // Slice k = 0 is the first slice (nearest the input), DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]             valid_q, valid_d;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DEPTH-1:0][DATA_W-1:0] data_q, data_d;

  // ready[k] is the ready seen by slice k; ready[DEPTH] is the downstream ready.
  logic [DEPTH:0] ready;

  // Source feeding slice 0 (input or skid entry).
  logic              src_valid;
  logic [CTRL_W-1:0] src_ctrl;
  logic [DATA_W-1:0] src_data;

  // Upstream view for every slice: element k is what slice k loads from.
  logic [DEPTH:0]             chain_valid;
  logic [DEPTH:0][CTRL_W-1:0] chain_ctrl;
  logic [DEPTH:0][DATA_W-1:0] chain_data;

  logic       alive_q;
  logic       in_fire;
  logic       out_fire;
  logic [2:0] occ_q, occ_d;

  // Ready chain: a slice can load if it is empty or its occupant moves on.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ready[k] = ~valid_q[k] | ready[k+1];
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;

  // Registered ready: only depends on whether the skid slot is free.
  assign in_ready = alive_q & ~skid_valid_q;
  assign in_fire  = in_valid & in_ready;

  // A parked skid entry is older than anything on the input, so it goes first.
  assign src_valid = skid_valid_q | in_fire;
  assign src_ctrl  = skid_valid_q ? skid_ctrl_q : in_ctrl;
  assign src_data  = skid_valid_q ? skid_data_q : in_data;

  // Skid next state: drain into slice 0, or catch an input slice 0 cannot take.
  always_comb begin
    skid_valid_d = skid_valid_q;
    skid_ctrl_d  = skid_ctrl_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      skid_valid_d = 1'b0;
      skid_ctrl_d  = '0;
    end else if (skid_valid_q) begin
      if (ready[0]) begin
        skid_valid_d = 1'b0;
        skid_ctrl_d  = '0;
      end
    end else if (in_fire && !ready[0]) begin
      skid_valid_d = 1'b1;
      skid_ctrl_d  = in_ctrl;
      skid_data_d  = in_data;
    end
  end

  // Skid register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_q <= 1'b0;
      skid_ctrl_q  <= '0;
      skid_data_q  <= '0;
    end else begin
      skid_valid_q <= skid_valid_d;
      skid_ctrl_q  <= skid_ctrl_d;
      skid_data_q  <= skid_data_d;
    end
  end
`else
  // Pass-through ready: combinational from out_ready via the ready chain.
  assign in_ready  = alive_q & ready[0];
  assign in_fire   = in_valid & in_ready;
  assign src_valid = in_fire;
  assign src_ctrl  = in_ctrl;
  assign src_data  = in_data;
`endif

  assign chain_valid = {valid_q, src_valid};
  assign chain_ctrl  = {ctrl_q, src_ctrl};
  assign chain_data  = {data_q, src_data};

  // Slice next state: flush clears valid/ctrl; a load of a bubble keeps old data.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      ctrl_d  = '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (ready[k]) begin
          valid_d[k] = chain_valid[k];
          ctrl_d[k]  = chain_valid[k] ? chain_ctrl[k] : '0;
          if (chain_valid[k]) data_d[k] = chain_data[k];
        end
      end
    end
  end

  // Slice register state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= '0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_ctrl  = ctrl_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_fire  = out_valid & out_ready;

  // Occupancy next state: +1 on accept, -1 on consume, cleared by flush.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occ_d = occ_q + 3'd1;
        2'b01:   occ_d = occ_q - 3'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  // Occupancy counter and the post-reset enable that holds in_ready low in reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q   <= '0;
      alive_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      alive_q <= 1'b1;
    end
  end

  assign occupancy = occ_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: four instances (DEPTH 1..4) share stimulus; each is
// compared every cycle against a queue-of-entries model in which every entry
// advances one position per cycle unless the position ahead stays occupied.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_REG_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif
  localparam int NDUT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;

  logic        o_ready [NDUT];
  logic        o_valid [NDUT];
  logic [7:0]  o_ctrl  [NDUT];
  logic [31:0] o_data  [NDUT];
  logic [2:0]  o_occ   [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    pipe_stage_reg #(
      .DATA_W(32),
      .CTRL_W(8),
      .DEPTH (g + 1)
    ) u_dut (
      .clock    (clk),
      .reset_n  (rst_n),
      .in_valid (in_valid),
      .in_ready (o_ready[g]),
      .in_ctrl  (in_ctrl),
      .in_data  (in_data),
      .flush    (flush),
      .out_valid(o_valid[g]),
      .out_ready(out_ready),
      .out_ctrl (o_ctrl[g]),
      .out_data (o_data[g]),
      .occupancy(o_occ[g])
    );
  end

  int n_vec = 0;
  int n_err = 0;

  // Model: entries ordered oldest first; position -1 = skid, 0..D-1 = slices.
  int          m_cnt  [NDUT];
  int          m_pos  [NDUT][6];
  int          m_np   [NDUT][6];
  logic [7:0]  m_ctrl [NDUT][6];
  logic [31:0] m_data [NDUT][6];
  bit          m_rdy  [NDUT];
  bit          m_slot0[NDUT];
  bit          alive = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic plan(input int d);
    int dep = d + 1;
    bit skid_full;
    for (int i = 0; i < m_cnt[d]; i++) begin
      if (i == 0) begin
        if (m_pos[d][0] == dep - 1) m_np[d][0] = out_ready ? dep : dep - 1;
        else m_np[d][0] = m_pos[d][0] + 1;
      end else begin
        m_np[d][i] = (m_pos[d][i] + 1 != m_np[d][i-1]) ? m_pos[d][i] + 1 : m_pos[d][i];
      end
    end
    m_slot0[d] = (m_cnt[d] == 0) || (m_np[d][m_cnt[d]-1] != 0);
    skid_full  = (m_cnt[d] > 0) && (m_pos[d][m_cnt[d]-1] < 0);
    m_rdy[d]   = alive && (Skid ? !skid_full : m_slot0[d]);
  endtask

  task automatic commit(input int d);
    int dep = d + 1;
    int n = 0;
    if (flush) begin
      m_cnt[d] = 0;
      return;
    end
    for (int i = 0; i < m_cnt[d]; i++) begin
      if (m_np[d][i] < dep) begin
        m_pos[d][n]  = m_np[d][i];
        m_ctrl[d][n] = m_ctrl[d][i];
        m_data[d][n] = m_data[d][i];
        n++;
      end
    end
    if (in_valid && m_rdy[d]) begin
      m_pos[d][n]  = m_slot0[d] ? 0 : -1;
      m_ctrl[d][n] = in_ctrl;
      m_data[d][n] = in_data;
      n++;
    end
    m_cnt[d] = n;
  endtask

  task automatic check_dut(input int d);
    bit ov = (m_cnt[d] > 0) && (m_pos[d][0] == d);
    chk($sformatf("D%0d out_valid", d + 1), o_valid[d], ov);
    chk($sformatf("D%0d occupancy", d + 1), o_occ[d], m_cnt[d]);
    chk($sformatf("D%0d in_ready", d + 1), o_ready[d], m_rdy[d]);
    chk($sformatf("D%0d out_ctrl", d + 1), o_ctrl[d], ov ? m_ctrl[d][0] : 8'h00);
    if (ov) chk($sformatf("D%0d out_data", d + 1), o_data[d], m_data[d][0]);
  endtask

  // Called at posedge+1 with inputs driven: settle, predict, compare.
  task automatic pre();
    #3;
    for (int d = 0; d < NDUT; d++) begin
      plan(d);
      check_dut(d);
    end
  endtask

  task automatic post();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < NDUT; d++) commit(d);
    alive = rst_n;
    #1;
  endtask

  task automatic run_cycle();
    pre();
    post();
  endtask

  task automatic chk_reset_all(input string tag);
    for (int d = 0; d < NDUT; d++) begin
      chk($sformatf("%s D%0d out_valid", tag, d + 1), o_valid[d], 0);
      chk($sformatf("%s D%0d out_ctrl", tag, d + 1), o_ctrl[d], 0);
      chk($sformatf("%s D%0d out_data", tag, d + 1), o_data[d], 0);
      chk($sformatf("%s D%0d occupancy", tag, d + 1), o_occ[d], 0);
      chk($sformatf("%s D%0d in_ready", tag, d + 1), o_ready[d], 0);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [7:0]  ic;
    logic [31:0] id;
    logic        ev;
    logic [7:0]  ec;
    logic [31:0] ed;
    int          eocc;
  } vec_t;

  vec_t tbl[7];
  logic [31:0] got[$];
  logic [31:0] next_val;
  logic [31:0] last_out;
  bit          seen;
  logic        r0;
  int          orb;

  initial begin
    // DEPTH=2, out_ready=1 throughout, three back-to-back entries.
    tbl[0] = '{1'b1, 8'h01, 32'h11, 1'b0, 8'h00, 32'h0,  0};
    tbl[1] = '{1'b1, 8'h02, 32'h22, 1'b0, 8'h00, 32'h0,  1};
    tbl[2] = '{1'b1, 8'h03, 32'h33, 1'b1, 8'h01, 32'h11, 2};
    tbl[3] = '{1'b0, 8'h00, 32'h0,  1'b1, 8'h02, 32'h22, 2};
    tbl[4] = '{1'b0, 8'h00, 32'h0,  1'b1, 8'h03, 32'h33, 1};
    tbl[5] = '{1'b0, 8'h00, 32'h0,  1'b0, 8'h00, 32'h0,  0};
    tbl[6] = '{1'b0, 8'h00, 32'h0,  1'b0, 8'h00, 32'h0,  0};
    for (int d = 0; d < NDUT; d++) m_cnt[d] = 0;

    // Reset state.
    #1;
    chk_reset_all("reset");
    post();
    run_cycle();
    rst_n = 1'b1;
    run_cycle();  // in_ready still low before the first edge after release
    run_cycle();
    run_cycle();

    // Table: latency and throughput at DEPTH=2.
    out_ready = 1'b1;
    for (int r = 0; r < 7; r++) begin
      in_valid = tbl[r].iv;
      in_ctrl  = tbl[r].ic;
      in_data  = tbl[r].id;
      pre();
      chk($sformatf("tbl%0d out_valid", r), o_valid[1], tbl[r].ev);
      chk($sformatf("tbl%0d out_ctrl", r), o_ctrl[1], tbl[r].ec);
      chk($sformatf("tbl%0d occupancy", r), o_occ[1], tbl[r].eocc);
      chk($sformatf("tbl%0d in_ready", r), o_ready[1], 1);
      if (tbl[r].ev) chk($sformatf("tbl%0d out_data", r), o_data[1], tbl[r].ed);
      post();
    end

    // Stall: out_ready low for 4 cycles with continuous input.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_ctrl = 8'h10 + 8'(i);
      in_data = 32'h40 + i;
      run_cycle();
    end
    in_data = 32'h44;
    pre();
    chk("stall occupancy", o_occ[1], Skid ? 3 : 2);
    chk("stall in_ready", o_ready[1], 0);
    chk("stall out_data", o_data[1], 32'h40);
    post();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    got.delete();
    for (int i = 0; i < 8; i++) begin
      pre();
      if (o_valid[1]) got.push_back(o_data[1]);
      post();
    end
    chk("drain count", got.size(), Skid ? 3 : 2);
    for (int i = 0; i < got.size() && i < 3; i++) chk($sformatf("drain %0d", i), got[i], 32'h40 + i);

    // Flush a full DEPTH=3 stage while a 0xFF-ctrl entry is offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h33;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'h70 + i;
      run_cycle();
    end
    chk("pre-flush occupancy", o_occ[2], Skid ? 4 : 3);
    flush   = 1'b1;
    in_ctrl = 8'hFF;
    in_data = 32'hDEAD;
    run_cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    pre();
    chk("flush occupancy", o_occ[2], 0);
    chk("flush out_valid", o_valid[2], 0);
    chk("flush out_ctrl", o_ctrl[2], 0);
    post();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pre();
      chk("flushed never out", o_ctrl[2] == 8'hFF, 0);
      post();
    end

    // Asynchronous reset with DEPTH=2 holding 0xAA, 0xBB.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hAA;
    run_cycle();
    in_data = 32'hBB;
    run_cycle();
    in_valid = 1'b0;
    run_cycle();
    chk("pre-reset occupancy", o_occ[1], 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_all("async reset");
    for (int d = 0; d < NDUT; d++) m_cnt[d] = 0;
    alive = 1'b0;
    @(posedge clk);
    #1;
    run_cycle();
    rst_n = 1'b1;
    run_cycle();
    in_valid  = 1'b1;
    in_data   = 32'h5A;
    out_ready = 1'b1;
    seen      = 1'b0;
    for (int i = 0; i < 6; i++) begin
      pre();
      if (o_ready[1]) begin
        post();
        in_valid = 1'b0;
      end else begin
        post();
      end
      if (o_valid[1] && !seen) begin
        seen = 1'b1;
        chk("first after reset", o_data[1], 32'h5A);
      end
    end
    chk("output after reset seen", seen, 1);
    in_valid = 1'b0;

`ifdef PIPE_STAGE_REG_SKID_EN
    // DEPTH=1 skid build with toggling out_ready and counting input.
    next_val = 32'd1;
    last_out = 32'd0;
    in_valid = 1'b1;
    orb      = 0;
    for (int i = 0; i < 24; i++) begin
      out_ready = (i % 2) == 0;
      in_data   = next_val;
      pre();
      r0        = o_ready[0];
      out_ready = ~out_ready;
      #1;
      chk("skid in_ready indep", o_ready[0], r0);
      out_ready = ~out_ready;
      #1;
      if (o_valid[0] && out_ready) begin
        chk("skid order", o_data[0], last_out + 1);
        last_out = o_data[0];
        orb++;
      end
      if (o_ready[0]) next_val = next_val + 1;
      @(posedge clk);
      for (int d = 0; d < NDUT; d++) commit(d);
      #1;
    end
    chk("skid outputs seen", orb > 5, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) run_cycle();
`endif

    // Random traffic against the model on all depths.
    for (int c = 0; c < 10000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      in_ctrl   = 8'($urandom);
      in_data   = $urandom;
      out_ready = ((c / 500) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      flush     = $urandom_range(0, 63) == 0;
      run_cycle();
    end
    flush = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32, width of the datapath payload (ALU result, store data, PC values packed by the caller).
REQ-002 Parameter CTRL_W, default 8, width of the control payload (write enables, branch flags, select fields); all-zero SHALL mean "no side effect" (bubble).
REQ-003 Parameter DEPTH, default 1, legal range 1..4, number of register slices in series.
REQ-004 CLOCK  input  1  single clock; all state updates on rising edge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 IN_VALID  input  1  upstream offers an entry this cycle.
REQ-007 IN_READY  output  1  stage accepts the offered entry this cycle.
REQ-008 IN_CTRL  input  CTRL_W  control payload.
REQ-009 IN_DATA  input  DATA_W  datapath payload.
REQ-010 FLUSH  input  1  discard every held entry (branch mispredict / exception).
REQ-011 OUT_VALID  output  1  last slice holds a valid entry.
REQ-012 OUT_READY  input  1  downstream consumes the entry this cycle.
REQ-013 OUT_CTRL  output  CTRL_W  control payload of last slice.
REQ-014 OUT_DATA  output  DATA_W  datapath payload of last slice.
REQ-015 OCCUPANCY  output  3  count of valid entries held (slices plus skid entry), 0..5.

Function
REQ-016 Transfer at input SHALL occur when IN_VALID & IN_READY; at output when OUT_VALID & OUT_READY.
REQ-017 Slice k SHALL load when its ready is high: ready_k = ~valid_k | ready_(k+1); ready after the last slice = OUT_READY.
REQ-018 On load, slice k SHALL take valid, ctrl and data from slice k-1 (slice 1 from the input); if the source is not valid, slice k SHALL load valid=0 and ctrl=0, data unchanged.
REQ-019 Latency input-to-output SHALL be exactly DEPTH cycles with no backpressure; throughput one entry per cycle.
REQ-020 A held valid entry SHALL NOT change while its slice is not ready (stall holds all fields).
REQ-021 OUT_CTRL SHALL be all-zero whenever OUT_VALID is 0.
REQ-022 FLUSH high SHALL, at the next edge, clear every valid bit and ctrl field (including the skid entry); an input transfer in the same cycle SHALL be discarded; FLUSH SHALL take priority over load and hold.
REQ-023 OCCUPANCY SHALL increment on input transfer, decrement on output transfer, be unchanged when both occur, and be 0 after FLUSH.
REQ-024 Without the skid option, IN_READY = ready_1 (combinational from OUT_READY).
REQ-025 Data fields SHALL never be cleared except by reset.

Reset
REQ-026 RESET_N low SHALL immediately clear all valid bits, ctrl fields, data fields, skid entry and OCCUPANCY to 0, independent of CLOCK.
REQ-027 While RESET_N is low IN_READY SHALL be 0; after deassertion IN_READY SHALL be 1 from the first edge.
REQ-028 Reset asserted mid-stall SHALL drop all entries; no partial entry SHALL appear after release.

Configuration
REQ-029 Macro PIPE_STAGE_REG_SKID_EN defined: a one-entry skid register SHALL precede slice 1; IN_READY = ~skid_valid (registered, no combinational path from OUT_READY); an accepted entry that slice 1 cannot take SHALL go to the skid register, and slice 1 SHALL load from the skid register in preference to the input; entry order SHALL be preserved; capacity DEPTH+1.
REQ-030 Macro undefined: no skid register; capacity DEPTH; behaviour per REQ-024.

Verification
REQ-031 DEPTH=2, OUT_READY=1, inputs 0x11,0x22,0x33 on consecutive cycles -> OUT_DATA 0x11,0x22,0x33 on cycles 2,3,4, OUT_VALID high for exactly 3 cycles.
REQ-032 DEPTH=2, OUT_READY=0 for 4 cycles while IN_VALID=1 -> OCCUPANCY reaches 2 (3 with skid), IN_READY low, OUT_DATA held at first entry; release -> entries drain in order, none lost or duplicated.
REQ-033 DEPTH=3 full, FLUSH pulse with IN_VALID=1 ctrl=0xFF -> next cycle OCCUPANCY=0, OUT_VALID=0, OUT_CTRL=0x00; flushed input never appears at output.
REQ-034 RESET_N low asynchronously mid-transfer with DEPTH=2 holding 0xAA,0xBB -> all outputs 0 before next edge; after release first output equals next accepted input.
REQ-035 Skid build, DEPTH=1, OUT_READY toggling 1,0,1,0 with continuous input 1,2,3,4,... -> IN_READY never depends combinationally on OUT_READY; output sequence strictly 1,2,3,... without gaps or repeats.
REQ-036 Random IN_VALID/OUT_READY for 10000 cycles, all DEPTH values -> scoreboard order match, OCCUPANCY equals scoreboard count every cycle.
